// File: rtl/c13_mult_sequencer_if.sv
// Operand/result handshake bundle for c13_mult_sequencer.
// RW must match the sequencer's result width (2*OPW, or ACC_W when C13_MAC_EN is defined).
interface c13_mult_sequencer_if #(
  parameter int unsigned OPW = 8,
  parameter int unsigned RW  = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic           acc_clr;
  logic           out_valid;
  logic           out_ready;
  logic [RW-1:0]  product;

  modport master (
    output in_valid, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, acc_clr, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/c13_mult_sequencer.sv
// Time-multiplexes an external 4x4 multiplier core to form an OPW x OPW product by nibble shift-add.
// Optional build macro C13_MAC_EN: accumulate successive products into an ACC_W-bit total.
module c13_mult_sequencer #(
  parameter int unsigned OPW   = 8,
  parameter int unsigned ACC_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  c13_mult_sequencer_if.slave  bus,
  output logic [3:0]           pp_m,
  output logic [3:0]           pp_q,
  input  logic [7:0]           pp_p,
  output logic                 busy
);

`ifdef C13_MAC_EN
  localparam int unsigned RW = ACC_W;
`else
  localparam int unsigned RW = 2 * OPW;
`endif
  localparam int unsigned NW = OPW / 4;
  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [OPW-1:0] a_lat, b_lat;
  logic [CW-1:0]  i_cnt, j_cnt;
  logic [RW-1:0]  acc, acc_sum, term, product_r;
  logic           accept, last;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (i_cnt == CW'(NW - 1)) && (j_cnt == CW'(NW - 1));

  // Partial product weight is 4*(i+j) bits.
  assign term    = RW'(pp_p) << {({1'b0, i_cnt} + {1'b0, j_cnt}), 2'b00};
  assign acc_sum = acc + term;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.product   = product_r;
  assign busy          = (state == CALC) || (state == DONE);

`ifndef C13_MAC_EN
  logic unused_acc_clr;
  assign unused_acc_clr = bus.acc_clr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pp_m      = '0;
    pp_q      = '0;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        pp_m = a_lat[{i_cnt, 2'b00} +: 4];
        pp_q = b_lat[{j_cnt, 2'b00} +: 4];
        if (last) state_nxt = DONE;
      end
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // product_r is loaded with the final sum on the last CALC edge so it equals acc in DONE
  // yet holds its value while the next operation accumulates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat     <= '0;
      b_lat     <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      acc       <= '0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_lat <= bus.a;
            b_lat <= bus.b;
            i_cnt <= '0;
            j_cnt <= '0;
`ifdef C13_MAC_EN
            if (bus.acc_clr) acc <= '0;
`else
            acc <= '0;
`endif
          end
        end
        CALC: begin
          acc <= acc_sum;
          if (i_cnt == CW'(NW - 1)) begin
            i_cnt <= '0;
            j_cnt <= j_cnt + 1'b1;
          end else begin
            i_cnt <= i_cnt + 1'b1;
          end
          if (last) product_r <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_c13_mult_sequencer.sv
// Self-checking bench for c13_mult_sequencer (OPW=8): directed cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_c13_mult_sequencer;
  localparam int unsigned OPW   = 8;
  localparam int unsigned ACC_W = 24;
`ifdef C13_MAC_EN
  localparam int unsigned RW = ACC_W;
`else
  localparam int unsigned RW = 2 * OPW;
`endif
  localparam int N = (OPW / 4) * (OPW / 4);

  logic       clk;
  logic       rst_n;
  logic [3:0] pp_m, pp_q;
  logic [7:0] pp_p;
  logic       busy;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  c13_mult_sequencer_if #(.OPW(OPW), .RW(RW)) bus ();

  c13_mult_sequencer #(.OPW(OPW), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .pp_m (pp_m),
    .pp_q (pp_q),
    .pp_p (pp_p),
    .busy (busy)
  );

  // External 4x4 core
  assign pp_p = {4'b0, pp_m} * {4'b0, pp_q};

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation finishes N edges later; result is a*b
  // (or running total in the MAC build); result held until taken by out_ready.
  bit            m_idle;
  bit            m_valid;
  int            m_rem;
  logic [RW-1:0] m_pend, m_prod, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle  = 1;
      m_valid = 0;
      m_rem   = 0;
      m_pend  = '0;
      m_prod  = '0;
      m_acc   = '0;
    end else if (m_idle) begin
      if (bus.in_valid) begin
`ifdef C13_MAC_EN
        m_acc  = (bus.acc_clr ? RW'(0) : m_acc) + RW'(bus.a) * RW'(bus.b);
        m_pend = m_acc;
`else
        m_pend = RW'(bus.a) * RW'(bus.b);
`endif
        m_rem  = N;
        m_idle = 0;
      end
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_valid = 1;
        m_prod  = m_pend;
      end
    end else if (m_valid && bus.out_ready) begin
      m_valid = 0;
      m_idle  = 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", 64'(bus.in_ready), 64'(m_idle));
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("busy", 64'(busy), 64'(!m_idle));
      check("product", 64'(bus.product), 64'(m_prod));
      if (m_rem == 0) check("pp_idle", 64'({pp_m, pp_q}), 64'(0));
    end
  end

  task automatic do_op(input logic [OPW-1:0] ta, input logic [OPW-1:0] tb_, input bit clr,
                       output logic [RW-1:0] res, output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 20) check("in_ready_timeout", 64'(bus.in_ready), 64'(1));
    bus.a = ta; bus.b = tb_; bus.acc_clr = clr; bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    bus.a = OPW'($urandom); bus.b = OPW'($urandom); bus.acc_clr = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 50) check("out_valid_timeout", 64'(bus.out_valid), 64'(1));
    res = bus.product;
  endtask

  task automatic take();
    bus.out_ready = 1;
    @(posedge clk); #1;
  endtask

  logic [RW-1:0] res;
  int            lat, gap;
  logic [OPW-1:0] held_prod;

  initial begin
    rst_n = 1;
    bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.acc_clr = 0; bus.out_ready = 0;
    #2 rst_n = 0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_product", 64'(bus.product), 64'(0));
    check("rst_pp", 64'({pp_m, pp_q}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    cmp_en = 1;

    // 1: basic latency and value
    bus.out_ready = 1;
    do_op(8'h12, 8'h34, 1, res, lat);
    check("t1_latency", 64'(lat), 64'(4));
    check("t1_product", 64'(res), 64'h03A8);
    @(posedge clk); #1;
    check("t1_busy_after", 64'(busy), 64'(0));

    // 2: extremes
    do_op(8'hFF, 8'hFF, 1, res, lat);
    check("t2_ffxff", 64'(res), 64'hFE01);
    take();
    do_op(8'h00, 8'hA5, 1, res, lat);
    check("t2_zero", 64'(res), 64'h0000);
    take();

    // 3: stall in DONE, in_valid pulse must be ignored
    bus.out_ready = 0;
    do_op(8'hC7, 8'h2B, 1, res, lat);
    check("t3_product", 64'(res), 64'hC7 * 64'h2B);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = (k == 3); bus.a = 8'h77; bus.b = 8'h66;
      @(posedge clk); #1;
      check("t3_hold_product", 64'(bus.product), 64'(res));
      check("t3_hold_valid", 64'(bus.out_valid), 64'(1));
      check("t3_no_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.in_valid = 0;
    take();
    check("t3_back_idle", 64'(bus.in_ready), 64'(1));

    // 4: reset two cycles into CALC
    bus.out_ready = 0;
    bus.a = 8'h9C; bus.b = 8'h4B; bus.acc_clr = 1; bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("t4_in_ready", 64'(bus.in_ready), 64'(1));
    check("t4_out_valid", 64'(bus.out_valid), 64'(0));
    check("t4_product", 64'(bus.product), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    bus.out_ready = 1;
    do_op(8'h03, 8'h05, 1, res, lat);
    check("t4_after", 64'(res), 64'h000F);
    check("t4_latency", 64'(lat), 64'(4));
    take();

    // 5: back-to-back with in_valid and out_ready held high
    bus.a = 8'h10; bus.b = 8'h10; bus.acc_clr = 1; bus.in_valid = 1; bus.out_ready = 1;
    @(posedge clk); #1;
    bus.a = 8'h0F; bus.b = 8'h11;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("t5_first", 64'(bus.product), 64'h0100);
    check("t5_latency", 64'(lat), 64'(4));
    @(posedge clk); #1;
    gap = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    gap++;
    while (!bus.out_valid && gap < 50) begin
      @(posedge clk); #1; gap++;
    end
    check("t5_second", 64'(bus.product), 64'h00FF);
    check("t5_spacing", 64'(gap - 1), 64'(5));
    take();

`ifdef C13_MAC_EN
    // 6: accumulate
    do_op(8'd3, 8'd5, 1, res, lat);
    check("t6_clr", 64'(res), 64'h00000F);
    take();
    do_op(8'd7, 8'd9, 0, res, lat);
    check("t6_acc", 64'(res), 64'h00004E);
    take();
    do_op(8'd1, 8'd1, 1, res, lat);
    check("t6_reclr", 64'(res), 64'h000001);
    take();
`endif

    // Randomized traffic, compared every cycle by the model
    for (int c = 0; c < 800; c++) begin
      bus.in_valid  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: bus.a = 8'hFF;
        1: bus.a = 8'h00;
        default: bus.a = OPW'($urandom);
      endcase
      bus.b         = ($urandom_range(0, 5) == 0) ? 8'hFF : OPW'($urandom);
      bus.acc_clr   = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 0; bus.out_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    check("final_idle", 64'(bus.in_ready), 64'(1));

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
